// File: rtl/pcie_rx_ingress.sv
// Ingress queue for link request beats, issuing them downstream one at a time and
// holding off after each read until its completion or a timeout. Macro: PCIE_RX_DROP_CNT_EN.
module pcie_rx_ingress #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [63:0] rx_data,
    input  logic        rx_is_write,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        out_is_write,
    input  logic        rsp_valid,
    input  logic        clr_status,
    output logic [6:0]  credits,
    output logic        overflow,
    output logic        timeout_err,
    output logic [15:0] drop_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PtrOne  = AW'(1);
    localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
    localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);
    localparam logic [15:0]   TimerMax = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWaitRsp} state_e;

    state_e        state_q;
    logic [64:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [15:0]   timer_q;
    logic          out_valid_q, overflow_q, timeout_err_q;
    logic [64:0]   head;
    logic          full, pop, push, drop;

    assign head = mem[rd_ptr_q];
    assign full = (count_q == CntFull);
    assign pop  = out_valid_q && out_ready;
    // A full queue still takes a beat when the head leaves on the same edge.
    assign push = rx_valid && (!full || pop);
    assign drop = rx_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {rx_is_write, rx_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntOne;
                2'b01:   count_q <= count_q - CntOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            out_valid_q   <= 1'b0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (clr_status) begin
                timeout_err_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q     <= StIssue;
                        out_valid_q <= 1'b1;
                    end
                end
                StIssue: begin
                    if (out_ready) begin
                        if (!head[64]) begin
                            state_q     <= StWaitRsp;
                            out_valid_q <= 1'b0;
                            timer_q     <= '0;
                        end else if (count_q <= CntOne) begin
                            state_q     <= StIdle;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                StWaitRsp: begin
                    if (rsp_valid) begin
                        state_q <= StIdle;
                    end else if (timer_q == TimerMax) begin
                        state_q       <= StIdle;
                        timeout_err_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (clr_status) begin
            overflow_q <= 1'b0;
        end
    end

`ifdef PCIE_RX_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end else if (clr_status) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0000;
`endif

    assign out_valid    = out_valid_q;
    assign out_data     = head[63:0];
    assign out_is_write = head[64];
    assign credits      = 7'(DEPTH) - 7'(count_q);
    assign overflow     = overflow_q;
    assign timeout_err  = timeout_err_q;

endmodule
